data_mem_stage: RTL and testbench

//  Data-memory access stage of the pipelined MIPS core, sitting between EX_MEM and MEM_WB.

---
 rtl/data_mem_stage_if.sv | 20 ++
 rtl/data_mem_stage.sv | 98 +++++++++
 tb/tb_data_mem_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_stage_if.sv
// rtl/data_mem_stage_if.sv - request/response bundle between the pipeline and the data-memory stage
interface data_mem_stage_if;
  logic        MemRead_Mem;
  logic        MemWrite_Mem;
  logic [31:0] ALUOUT_Mem;
  logic [31:0] WriteData_Mem;
  logic [31:0] ReadData_Mem;
  logic        Stall_Mem;
  logic        AddrErr_Mem;

  modport master (
    output MemRead_Mem, MemWrite_Mem, ALUOUT_Mem, WriteData_Mem,
    input  ReadData_Mem, Stall_Mem, AddrErr_Mem
  );

  modport slave (
    input  MemRead_Mem, MemWrite_Mem, ALUOUT_Mem, WriteData_Mem,
    output ReadData_Mem, Stall_Mem, AddrErr_Mem
  );
endinterface

// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MIPS data-memory stage: fixed-latency word RAM access with pipeline stall
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  data_mem_stage_if.slave mem
);
  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req;
  logic              stall_c;
  logic              done_c;
  logic              done;
  logic              misalign;
  logic              do_load;
  logic              do_store;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ram [DEPTH];
  logic              unused_addr_bits;

  assign req = mem.MemRead_Mem | mem.MemWrite_Mem;
  assign idx = mem.ALUOUT_Mem[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign         = |mem.ALUOUT_Mem[1:0];
  assign unused_addr_bits = ^mem.ALUOUT_Mem[31:ADDR_W+2];
`else
  assign misalign         = 1'b0;
  assign unused_addr_bits = ^{mem.ALUOUT_Mem[31:ADDR_W+2], mem.ALUOUT_Mem[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    if (WAIT_CYCLES == 0) begin
      done_c = req;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            stall_c = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // A dropped request means the pipeline flushed this access: abandon it.
          if (!req) begin
            state_d = S_IDLE;
          end else if (cnt_q != '0) begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with reset keeps outputs quiet and drops any in-flight store while reset is held.
  assign done     = reset & done_c;
  assign do_store = done & mem.MemWrite_Mem & ~misalign;
  assign do_load  = done & mem.MemRead_Mem & ~mem.MemWrite_Mem & ~misalign;

  always_ff @(posedge clock) begin
    if (do_store) begin
      ram[idx] <= mem.WriteData_Mem;
    end
  end

  assign mem.ReadData_Mem = do_load ? ram[idx] : '0;
  assign mem.Stall_Mem    = reset & stall_c;
  assign mem.AddrErr_Mem  = done & misalign;
endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed and randomized checks of data_mem_stage at two latencies
module tb_data_mem_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  data_mem_stage_if bus_a ();
  data_mem_stage_if bus_b ();

  data_mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .clock (clock),
    .reset (reset),
    .mem   (bus_a.slave)
  );

  data_mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .mem   (bus_b.slave)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic [31:0] model_mem [2][256];
  logic [31:0] wr_log0 [$];
  logic [31:0] wr_log1 [$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (sel == 1'b0) begin
      bus_a.MemRead_Mem = rd; bus_a.MemWrite_Mem = wr;
      bus_a.ALUOUT_Mem = addr; bus_a.WriteData_Mem = wd;
    end else begin
      bus_b.MemRead_Mem = rd; bus_b.MemWrite_Mem = wr;
      bus_b.ALUOUT_Mem = addr; bus_b.WriteData_Mem = wd;
    end
  endtask

  task automatic sample(input bit sel, output logic st, output logic [31:0] rd, output logic ae);
    if (sel == 1'b0) begin
      st = bus_a.Stall_Mem; rd = bus_a.ReadData_Mem; ae = bus_a.AddrErr_Mem;
    end else begin
      st = bus_b.Stall_Mem; rd = bus_b.ReadData_Mem; ae = bus_b.AddrErr_Mem;
    end
  endtask

  // One full access: request at T, stall for the configured latency, check the completion cycle.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int w;
    bit mis;
    logic [31:0] exp_rd;
    logic st, ae;
    logic [31:0] rdat;
    w      = sel ? 0 : 2;
    mis    = ALIGN_EN && (addr % 4 != 0);
    exp_rd = (rd && !wr && !mis) ? model_mem[sel][widx(addr)] : 32'h0;
    drive(sel, rd, wr, addr, wd);
    for (int k = 0; k <= w; k++) begin
      @(negedge clock);
      sample(sel, st, rdat, ae);
      check({tag, "_stall"}, {31'b0, st}, {31'b0, k < w});
      if (k < w) begin
        check({tag, "_rd_early"}, rdat, 32'h0);
      end else begin
        check({tag, "_rdata"}, rdat, exp_rd);
        check({tag, "_addrerr"}, {31'b0, ae}, {31'b0, mis});
      end
      @(posedge clock);
      #1;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    if (wr && !mis) begin
      model_mem[sel][widx(addr)] = wd;
      if (sel == 1'b0) wr_log0.push_back(addr); else wr_log1.push_back(addr);
    end
  endtask

  initial begin
    logic st, ae;
    logic [31:0] rdat;
    logic [31:0] addr, data, base;
    bit sel;
    int j;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Outputs must stay quiet under reset even with a request presented.
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h55);
    #12;
    sample(1'b0, st, rdat, ae);
    check("reset_stall", {31'b0, st}, 32'h0);
    check("reset_rdata", rdat, 32'h0);
    check("reset_addrerr", {31'b0, ae}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st_10");
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, "ld_10");

    access(1'b1, 1'b0, 1'b1, 32'h4, 32'h12345678, "w0_st_4");
    access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, "w0_ld_4");

    access(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, "st_400");
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, "ld_wrap_0");

    access(1'b0, 1'b1, 1'b1, 32'h8, 32'h1, "rdwr_8");
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, "ld_8");

    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, "st_10b");
    access(1'b0, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, "st_13");
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, "ld_10_after_13");

    // Flush: request dropped mid-wait must not write and must release the stall.
    access(1'b0, 1'b0, 1'b1, 32'h30, 32'h11112222, "st_30");
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h99998888);
    @(negedge clock);
    sample(1'b0, st, rdat, ae);
    check("flush_stall_t", {31'b0, st}, 32'h1);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    sample(1'b0, st, rdat, ae);
    check("flush_stall_drop", {31'b0, st}, 32'h0);
    @(posedge clock);
    #1;
    access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, "ld_30_flush");

    // Reset asserted mid-wait with a store pending: store discarded.
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "st_20");
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h76543210);
    @(posedge clock);
    #1;
    #2;
    reset = 1'b0;
    #1;
    sample(1'b0, st, rdat, ae);
    check("midwait_rst_stall", {31'b0, st}, 32'h0);
    check("midwait_rst_rdata", rdat, 32'h0);
    check("midwait_rst_addrerr", {31'b0, ae}, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, "ld_20_after_rst");

    // Randomized traffic on both latencies, loads only from words with known contents.
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      if ((sel ? wr_log1.size() : wr_log0.size()) == 0 || $urandom_range(0, 1) == 0) begin
        addr = $urandom;
        data = $urandom;
        access(sel, 1'($urandom_range(0, 3) == 0), 1'b1, addr, data, "rnd_st");
      end else begin
        if (sel) begin
          j = $urandom_range(0, wr_log1.size() - 1);
          base = wr_log1[j];
        end else begin
          j = $urandom_range(0, wr_log0.size() - 1);
          base = wr_log0[j];
        end
        addr = (base - (base % 4)) + 32'($urandom_range(0, 7)) * 32'd1024 + 32'($urandom_range(0, 3));
        access(sel, 1'b1, 1'b0, addr, 32'h0, "rnd_ld");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
